demorgan_response_checker: RTL and testbench
============================================

# demorgan_response_checker

Synthesizable response checker that closes the loop on the three-input De Morgan stimulus benches. A driver applies 3-bit patterns `{a,b,c}` to a DUT and strobes `stim_valid`. This block waits a settle time, samples the DUT output `d`, and compares it against a parameterised truth table. It accumulates an error count and a per-pattern coverage map, and reports pass/fail once all 8 input combinations have been checked.

## Interface
Parameters:
- `EXPECT_TT`, default 8'h7F: expected `d` for each input index `{a,b,c}` (`a` is the MSB). The default is `~(a&b&c)`, which equals `~a|~b|~c`.
- `SETTLE`, default 2: clock cycles between `stim_valid` and sampling. Range 0..15.
- `CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1  clock. Only rising edges are used.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a check run.
- `stim_valid`  in  1  one-cycle pulse: a new pattern has just been applied to the DUT.
- `a`, `b`, `c`  in  1 each  pattern currently driven into the DUT.
- `d`  in  1  DUT response.
- `busy`  out  1  high in ARM, WAIT, SETTLE and SAMPLE.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid only while `done`=1; equals (`err_cnt`==0).
- `err_cnt`  out  CNT_W  count of mismatches. Saturates at all-ones.
- `coverage`  out  8  bit i is set once index i has been sampled.

## Operation
- On reset (`rst_n`=0 at a clock edge), all of the following hold after that edge:
  - state = IDLE
  - `busy`=0, `done`=0, `pass`=0
  - `err_cnt`=0, `coverage`=8'h00
  - settle counter = 0
  - capture outputs (if the macro is enabled) = 0
- FSM transitions:
  - IDLE: `start` → ARM.
  - ARM (1 cycle): clear `err_cnt`, `coverage` and the capture registers → WAIT.
  - WAIT: `stim_valid` → SETTLE, loading the counter with SETTLE. If SETTLE=0, go directly to SAMPLE.
  - SETTLE: decrement the counter each cycle; when it reaches 0 → SAMPLE. A `stim_valid` arriving in SETTLE reloads the counter to SETTLE; the earlier pattern is discarded and not sampled.
  - SAMPLE (1 cycle):
    - idx = `{a,b,c}`, read live in this cycle.
    - If `d` != `EXPECT_TT[idx]`: `err_cnt` increments, saturating.
    - `coverage[idx]` is set.
    - If the updated coverage is 8'hFF → DONE, otherwise → WAIT.
  - DONE: outputs hold. `start` → ARM, which begins a new run.
- Other input rules:
  - `start` in any state other than IDLE or DONE is ignored.
  - `stim_valid` in IDLE, ARM, SAMPLE or DONE is ignored.
- Repeated patterns are checked again every time they are sampled; each mismatch counts separately.
- `err_cnt` saturation: once all-ones, it stays there while mismatches continue.

## Timing
- All outputs are registered.
- `stim_valid` is high at edge k (the edge at which WAIT→SETTLE):
  - SAMPLE occupies the cycle following edge k+SETTLE.
  - `err_cnt` and `coverage` update at edge k+SETTLE+1.
- SETTLE=0: WAIT→SAMPLE at edge k, and the update happens at edge k+1.
- `done` rises at the same edge as the final coverage update.
- `start` at edge s: `busy`=1 from edge s. Counters read 0 after edge s+1.
- Reset asserted mid-run takes priority over every other event at that edge. It returns the block to IDLE with the full reset values.
- Minimum check rate: one pattern per SETTLE+2 cycles.

## Configuration
- Macro: `DEMORGAN_CHECKER_FIRST_FAIL_EN`.
- When defined, two extra output ports are added:
  - `first_fail_vld` (out, 1): set at the first mismatch of a run; stays set until ARM or reset.
  - `first_fail_idx` (out, 3): the `{a,b,c}` of that first mismatch. Later mismatches do not change it.
- When not defined, these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Correct NAND3 model; patterns 0..7 in order, one per 10 cycles, defaults → `done`=1, `pass`=1, `err_cnt`=0, `coverage`=8'hFF. The final update lands exactly SETTLE+1 edges after the 8th `stim_valid`.
- `d` stuck at 1, all 8 patterns → `err_cnt`=1 (only idx 7 mismatches), `pass`=0. With the macro: `first_fail_idx`=3'b111, `first_fail_vld`=1.
- CNT_W=2, `d` stuck inverted (every pattern mismatches), 8 patterns → `err_cnt` saturates at 2'b11, `pass`=0.
- `stim_valid` with pattern 5, followed by a second `stim_valid` 1 cycle later with pattern 6 → only `coverage[6]` is set, and the sample occurs SETTLE+1 edges after the second pulse.
- Reset pulled low after 4 of 8 patterns → next edge: IDLE, `busy`=0, `coverage`=0, `err_cnt`=0. Further `stim_valid` pulses leave the outputs unchanged until `start`.
- Patterns 0..6 applied, then 3 repeated with a wrong `d` → `done` stays 0, `err_cnt`=1. Applying pattern 7 correctly then gives `done`=1, `pass`=0.

Source files
------------

// File: rtl/demorgan_response_checker.sv
// Response checker for 3-input De Morgan DUTs: settle, sample, compare, cover.
// Optional first-mismatch capture ports: DEMORGAN_CHECKER_FIRST_FAIL_EN.
module demorgan_response_checker #(
  parameter logic [7:0]  EXPECT_TT = 8'h7F,
  parameter int unsigned SETTLE    = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stim_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       coverage
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
  ,
  output logic             first_fail_vld,
  output logic [2:0]       first_fail_idx
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [7:0]       cov_q, cov_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [2:0]       idx;
  logic             mism;

`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
  logic       ffv_q, ffv_d;
  logic [2:0] ffi_q, ffi_d;
`endif

  assign idx  = {a, b, c};
  assign mism = (d != EXPECT_TT[idx]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cov_d   = cov_q;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_ARM;
      end
      S_ARM: begin
        err_d   = '0;
        cov_d   = '0;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
        ffv_d   = 1'b0;
        ffi_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stim_valid) begin
          cnt_d   = SETTLE_LD;
          state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        // a fresh pattern restarts the settle window
        if (stim_valid) begin
          cnt_d = SETTLE_LD;
        end else if (cnt_q <= 4'd1) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SAMPLE: begin
        if (mism) begin
          if (err_q != {CNT_W{1'b1}}) err_d = err_q + 1'b1;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx;
          end
`endif
        end
        cov_d   = cov_q | (8'd1 << idx);
        state_d = (cov_d == 8'hFF) ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        if (start) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ARM) || (state_d == S_WAIT) ||
             (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
      cov_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cov_q   <= cov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_q;
  assign coverage = cov_q;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
`endif

endmodule

// File: tb/tb_demorgan_response_checker.sv
// Scoreboard bench for demorgan_response_checker against a NAND3 reference.
module tb_demorgan_response_checker;

  localparam int ST = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stim_valid = 1'b0;
  logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_cnt, coverage;
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
  logic       ffv;
  logic [2:0] ffi;
`endif

  demorgan_response_checker #(
    .EXPECT_TT(8'h7F),
    .SETTLE(ST),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stim_valid(stim_valid),
    .a(a),
    .b(b),
    .c(c),
    .d(d),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_cnt(err_cnt),
    .coverage(coverage)
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
    ,
    .first_fail_vld(ffv),
    .first_fail_idx(ffi)
`endif
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int         due;
    int         err;
    logic [7:0] cov;
    bit         dn;
  } exp_t;

  exp_t       sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         m_err = 0;
  logic [7:0] m_cov = '0;
  bit         m_run = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at edge %0d",
               nm, act, exp, edge_n);
    end
  endtask

  function automatic logic nand3(input logic [2:0] i);
    return !(i == 3'b111);
  endfunction

  // monitor: compare at the edge each sample result is due
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      if (sb[0].due == edge_n) begin
        e = sb.pop_front();
        chk("err_cnt", err_cnt, e.err);
        chk("coverage", coverage, e.cov);
        chk("done", done, e.dn);
        chk("pass", pass, e.dn && e.err == 0);
        chk("busy", busy, !e.dn);
      end else if (sb[0].due < edge_n) begin
        void'(sb.pop_front());
        chk("sample_missed", 0, 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_sample(input logic [2:0] idx, input logic dv,
                              input int due);
    if (dv != nand3(idx)) m_err = (m_err < 255) ? m_err + 1 : 255;
    m_cov[idx] = 1'b1;
    sb.push_back('{due, m_err, m_cov, m_cov == 8'hFF});
    if (m_cov == 8'hFF) m_run = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    chk("err_cleared", err_cnt, 0);
    chk("cov_cleared", coverage, 0);
    m_err = 0;
    m_cov = '0;
    m_run = 1;
  endtask

  task automatic apply(input logic [2:0] idx, input logic dv,
                       input int gap);
    int k;
    @(negedge clk);
    {a, b, c}  = idx;
    d          = dv;
    stim_valid = 1'b1;
    k          = edge_n + 1;
    @(negedge clk);
    stim_valid = 1'b0;
    if (m_run) model_sample(idx, dv, k + ST + 1);
    tick(gap - 1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_pass"}, pass, 0);
    chk({nm, "_err"}, err_cnt, 0);
    chk({nm, "_cov"}, coverage, 0);
  endtask

  initial begin
    int         k;
    int         n;
    logic [2:0] ri;
    tick(3);
    rst_n = 1'b1;
    chk_idle("reset");

    // correct NAND3, ordered, one pattern per 10 cycles
    do_start();
    for (int i = 0; i < 8; i++) apply(3'(i), nand3(3'(i)), 10);
    drain();

    // d stuck at 1: only index 7 mismatches
    do_start();
    for (int i = 0; i < 8; i++) apply(3'(i), 1'b1, ST + 2);
    drain();
`ifdef DEMORGAN_CHECKER_FIRST_FAIL_EN
    chk("first_fail_vld", ffv, 1);
    chk("first_fail_idx", ffi, 7);
`endif

    // random patterns, random errors, random spacing
    do_start();
    n = 0;
    while (m_run && n < 200) begin
      ri = 3'($urandom_range(0, 7));
      apply(ri, nand3(ri) ^ ($urandom_range(0, 3) == 0),
            $urandom_range(ST + 2, ST + 6));
      n++;
    end
    for (int i = 0; i < 8; i++)
      if (m_run && !m_cov[i]) apply(3'(i), nand3(3'(i)), ST + 2);
    drain();

    // second pulse during settle discards the first pattern
    do_start();
    @(negedge clk);
    {a, b, c}  = 3'd5;
    d          = 1'b1;
    stim_valid = 1'b1;
    @(negedge clk);
    {a, b, c}  = 3'd6;
    d          = 1'b1;
    k          = edge_n + 1;
    @(negedge clk);
    stim_valid = 1'b0;
    model_sample(3'd6, 1'b1, k + ST + 1);
    tick(ST + 2);
    for (int i = 0; i < 8; i++)
      if (i != 6) apply(3'(i), nand3(3'(i)), ST + 2);
    drain();

    // saturation: one index repeatedly wrong
    do_start();
    repeat (260) apply(3'd0, 1'b0, ST + 2);
    for (int i = 1; i < 8; i++) apply(3'(i), nand3(3'(i)), ST + 2);
    drain();

    // repeated pattern with wrong d, then completion
    do_start();
    for (int i = 0; i < 7; i++) apply(3'(i), nand3(3'(i)), ST + 2);
    apply(3'd3, 1'b0, ST + 2);
    apply(3'd7, nand3(3'd7), ST + 2);
    drain();

    // reset mid-run, then ignored stim_valid pulses
    do_start();
    for (int i = 0; i < 4; i++) apply(3'(i), 1'b0, ST + 2);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_run = 0;
    chk_idle("midreset");
    repeat (3) begin
      @(negedge clk);
      {a, b, c}  = 3'd7;
      d          = 1'b1;
      stim_valid = 1'b1;
      @(negedge clk);
      stim_valid = 1'b0;
      tick(ST + 2);
    end
    chk_idle("ignored_stim");
    do_start();
    for (int i = 7; i >= 0; i--) apply(3'(i), nand3(3'(i)), ST + 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
